// File: rtl/qam_symbol_mapper.sv
// ============================================================================
// Module   : qam_symbol_mapper
// Purpose  : Packs strobed serial bits into 4-QAM/16-QAM symbols and maps each
//            symbol to signed I/Q levels. GRAY_MAP_EN selects Gray axis coding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qam_symbol_mapper #(
   parameter int BITS_PER_SYM = 4,
   parameter int LVL_W        = 8,
   parameter int LVL_STEP     = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             map_en,
   input  logic             adat_in,
   input  logic             data_change,
   output logic [LVL_W-1:0] i_level,
   output logic [LVL_W-1:0] q_level,
   output logic             sym_valid,
   output logic [7:0]       sym_cnt,
   output logic             running
);

   localparam int CNT_W = (BITS_PER_SYM > 2) ? $clog2(BITS_PER_SYM) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_SYM - 1);

   localparam logic [LVL_W-1:0] LVL_M3 = LVL_W'(-3 * LVL_STEP);
   localparam logic [LVL_W-1:0] LVL_M1 = LVL_W'(-LVL_STEP);
   localparam logic [LVL_W-1:0] LVL_P1 = LVL_W'(LVL_STEP);
   localparam logic [LVL_W-1:0] LVL_P3 = LVL_W'(3 * LVL_STEP);

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic                    data_change_q;
   logic                    bit_stb;
   logic [CNT_W-1:0]        bit_cnt;
   // Only the earlier bits of a symbol need storage; the last bit is live on adat_in.
   logic [BITS_PER_SYM-2:0] sreg;
   logic [BITS_PER_SYM-1:0] sym_next;
   logic [LVL_W-1:0]        i_next;
   logic [LVL_W-1:0]        q_next;
   logic [0:0]              state;

   assign bit_stb  = data_change & ~data_change_q;
   assign sym_next = {sreg, adat_in};

   function automatic logic [LVL_W-1:0] map_pair(input logic [1:0] b);
      logic [1:0] ord;
`ifdef GRAY_MAP_EN
      ord = {b[1], b[1] ^ b[0]};
`else
      ord = b;
`endif
      case (ord)
         2'd0:    map_pair = LVL_M3;
         2'd1:    map_pair = LVL_M1;
         2'd2:    map_pair = LVL_P1;
         default: map_pair = LVL_P3;
      endcase
   endfunction

   if (BITS_PER_SYM == 4) begin : g_qam16
      assign i_next = map_pair(sym_next[3:2]);
      assign q_next = map_pair(sym_next[1:0]);
   end else if (BITS_PER_SYM == 2) begin : g_qam4
      assign i_next = sym_next[1] ? LVL_P1 : LVL_M1;
      assign q_next = sym_next[0] ? LVL_P1 : LVL_M1;
   end else begin : g_bad_bps
      $error("qam_symbol_mapper: BITS_PER_SYM must be 2 or 4");
      assign i_next = '0;
      assign q_next = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         data_change_q <= 1'b0;
         bit_cnt       <= '0;
         sreg          <= '0;
         i_level       <= '0;
         q_level       <= '0;
         sym_valid     <= 1'b0;
         sym_cnt       <= 8'd0;
         state         <= ST_FILL;
      end else begin
         data_change_q <= data_change;
         sym_valid     <= 1'b0;
         // Disable takes priority over a coinciding strobe, discarding the partial symbol.
         if (!map_en) begin
            bit_cnt <= '0;
            sreg    <= '0;
            state   <= ST_FILL;
         end else if (bit_stb) begin
            if (bit_cnt == LAST_BIT) begin
               bit_cnt   <= '0;
               sreg      <= '0;
               i_level   <= i_next;
               q_level   <= q_next;
               sym_valid <= 1'b1;
               sym_cnt   <= sym_cnt + 8'd1;
               state     <= ST_RUN;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
               sreg    <= sym_next[BITS_PER_SYM-2:0];
            end
         end
      end
   end

   assign running = (state == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_qam_symbol_mapper.sv
// ============================================================================
// Module   : tb_qam_symbol_mapper
// Purpose  : Self-checking bench for qam_symbol_mapper (16-QAM and 4-QAM builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qam_symbol_mapper;

   typedef struct {
      logic [3:0] bits;
      int         hold;
      logic [7:0] i_nat;
      logic [7:0] q_nat;
      logic [7:0] i_gray;
      logic [7:0] q_gray;
   } vec_t;

   typedef struct {
      logic [7:0] i;
      logic [7:0] q;
      logic [7:0] cnt;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       men4 = 1'b0, adat4 = 1'b0, dc4 = 1'b0;
   logic       men2 = 1'b0, adat2 = 1'b0, dc2 = 1'b0;
   logic [7:0] i4, q4l, cnt4, i2, q2l, cnt2;
   logic       valid4, run4, valid2, run2;

   int         checks = 0;
   int         passes = 0;
   exp_t       sb4[$];
   exp_t       sb2[$];
   logic [7:0] exp_cnt4 = 8'd0;
   logic [7:0] exp_cnt2 = 8'd0;
   logic [7:0] last_i4 = 8'd0;
   logic [7:0] last_q4 = 8'd0;
   vec_t       vecs[6];

   always #5 clock = ~clock;

   qam_symbol_mapper #(.BITS_PER_SYM(4), .LVL_W(8), .LVL_STEP(32)) dut4 (
      .clock(clock), .reset(reset), .map_en(men4), .adat_in(adat4), .data_change(dc4),
      .i_level(i4), .q_level(q4l), .sym_valid(valid4), .sym_cnt(cnt4), .running(run4)
   );

   qam_symbol_mapper #(.BITS_PER_SYM(2), .LVL_W(8), .LVL_STEP(32)) dut2 (
      .clock(clock), .reset(reset), .map_en(men2), .adat_in(adat2), .data_change(dc2),
      .i_level(i2), .q_level(q2l), .sym_valid(valid2), .sym_cnt(cnt2), .running(run2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [7:0] sel(input logic [7:0] nat, input logic [7:0] gray);
`ifdef GRAY_MAP_EN
      sel = gray;
`else
      sel = nat;
`endif
   endfunction

   always @(negedge clock) begin
      exp_t e;
      if (valid4) begin
         if (sb4.size() == 0) begin
            checks++;
            $display("FAIL sb4_unexpected: got sym_valid i=0x%0h q=0x%0h expected none", i4, q4l);
         end else begin
            e = sb4.pop_front();
            check("sb4_i", {24'd0, i4}, {24'd0, e.i});
            check("sb4_q", {24'd0, q4l}, {24'd0, e.q});
            check("sb4_cnt", {24'd0, cnt4}, {24'd0, e.cnt});
            check("sb4_running", {31'd0, run4}, 32'd1);
         end
      end
      if (valid2) begin
         if (sb2.size() == 0) begin
            checks++;
            $display("FAIL sb2_unexpected: got sym_valid i=0x%0h q=0x%0h expected none", i2, q2l);
         end else begin
            e = sb2.pop_front();
            check("sb2_i", {24'd0, i2}, {24'd0, e.i});
            check("sb2_q", {24'd0, q2l}, {24'd0, e.q});
            check("sb2_cnt", {24'd0, cnt2}, {24'd0, e.cnt});
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_bit4(input logic b, input int hold);
      adat4 = b;
      dc4   = 1'b1;
      repeat (hold) tick();
      dc4 = 1'b0;
      tick();
   endtask

   task automatic send_sym4(input logic [3:0] bits, input int hold,
                            input logic [7:0] ei, input logic [7:0] eq);
      for (int k = 3; k >= 1; k--) send_bit4(bits[k], hold);
      exp_cnt4 = exp_cnt4 + 8'd1;
      sb4.push_back('{ei, eq, exp_cnt4});
      last_i4 = ei;
      last_q4 = eq;
      send_bit4(bits[0], hold);
   endtask

   task automatic send_bit2(input logic b);
      adat2 = b;
      dc2   = 1'b1;
      tick();
      dc2 = 1'b0;
      tick();
   endtask

   task automatic send_sym2(input logic [1:0] bits, input logic [7:0] ei, input logic [7:0] eq);
      send_bit2(bits[1]);
      exp_cnt2 = exp_cnt2 + 8'd1;
      sb2.push_back('{ei, eq, exp_cnt2});
      send_bit2(bits[0]);
   endtask

   task automatic check_zero4(input string tag);
      check({tag, "_i"}, {24'd0, i4}, 32'd0);
      check({tag, "_q"}, {24'd0, q4l}, 32'd0);
      check({tag, "_valid"}, {31'd0, valid4}, 32'd0);
      check({tag, "_cnt"}, {24'd0, cnt4}, 32'd0);
      check({tag, "_running"}, {31'd0, run4}, 32'd0);
   endtask

   initial begin
      logic [1:0] rb;
      vecs[0] = '{4'b0110, 1, 8'hE0, 8'h20, 8'hE0, 8'h60};
      vecs[1] = '{4'b1111, 5, 8'h60, 8'h60, 8'h20, 8'h20};
      vecs[2] = '{4'b0000, 1, 8'hA0, 8'hA0, 8'hA0, 8'hA0};
      vecs[3] = '{4'b1010, 2, 8'h20, 8'h20, 8'h60, 8'h60};
      vecs[4] = '{4'b0111, 1, 8'hE0, 8'h60, 8'hE0, 8'h20};
      vecs[5] = '{4'b1100, 3, 8'h60, 8'hA0, 8'h20, 8'hA0};

      repeat (3) tick();
      check_zero4("rst4");
      check("rst2_i", {24'd0, i2}, 32'd0);
      check("rst2_cnt", {24'd0, cnt2}, 32'd0);
      check("rst2_running", {31'd0, run2}, 32'd0);
      reset = 1'b0;
      men4  = 1'b1;
      tick();

      for (int v = 0; v < 6; v++)
         send_sym4(vecs[v].bits, vecs[v].hold,
                   sel(vecs[v].i_nat, vecs[v].i_gray), sel(vecs[v].q_nat, vecs[v].q_gray));
      repeat (2) tick();
      check("vec_levels_hold_i", {24'd0, i4}, {24'd0, last_i4});

      // Partial symbol then disable: running must drop and levels hold
      send_bit4(1'b1, 1);
      send_bit4(1'b1, 1);
      men4 = 1'b0;
      repeat (3) tick();
      check("dis_running", {31'd0, run4}, 32'd0);
      check("dis_valid", {31'd0, valid4}, 32'd0);
      check("dis_hold_i", {24'd0, i4}, {24'd0, last_i4});
      check("dis_hold_q", {24'd0, q4l}, {24'd0, last_q4});
      check("dis_hold_cnt", {24'd0, cnt4}, {24'd0, exp_cnt4});
      men4 = 1'b1;
      tick();
      check("reen_running", {31'd0, run4}, 32'd0);
      send_sym4(4'b0000, 1, 8'hA0, 8'hA0);
      check("reen_running_after", {31'd0, run4}, 32'd1);

      // Strobe already high when enable rises must not be captured
      men4 = 1'b0;
      tick();
      adat4 = 1'b1;
      dc4   = 1'b1;
      repeat (2) tick();
      men4 = 1'b1;
      repeat (2) tick();
      dc4 = 1'b0;
      tick();
      send_sym4(4'b0110, 1, sel(8'hE0, 8'hE0), sel(8'h20, 8'h60));

      // Disable coinciding with the completing strobe discards the symbol
      send_bit4(1'b1, 1);
      send_bit4(1'b1, 1);
      send_bit4(1'b1, 1);
      adat4 = 1'b1;
      dc4   = 1'b1;
      men4  = 1'b0;
      tick();
      dc4 = 1'b0;
      tick();
      check("coinc_valid", {31'd0, valid4}, 32'd0);
      men4 = 1'b1;
      tick();
      send_sym4(4'b1010, 1, sel(8'h20, 8'h60), sel(8'h20, 8'h60));

      // Reset mid-symbol loses the partial bits
      send_bit4(1'b0, 1);
      send_bit4(1'b1, 1);
      send_bit4(1'b1, 1);
      reset = 1'b1;
      repeat (2) tick();
      check_zero4("midrst");
      reset    = 1'b0;
      exp_cnt4 = 8'd0;
      tick();
      send_sym4(4'b1010, 1, sel(8'h20, 8'h60), sel(8'h20, 8'h60));
      repeat (3) tick();

      // 4-QAM build and sym_cnt wrap
      men4 = 1'b0;
      men2 = 1'b1;
      tick();
      send_sym2(2'b10, 8'h20, 8'hE0);
      for (int n = 0; n < 256; n++) begin
         rb = 2'($urandom_range(0, 3));
         send_sym2(rb, rb[1] ? 8'h20 : 8'hE0, rb[0] ? 8'h20 : 8'hE0);
      end
      repeat (3) tick();
      check("wrap_cnt2", {24'd0, cnt2}, 32'd1);
      check("wrap_running2", {31'd0, run2}, 32'd1);
      check("sb4_drain", sb4.size(), 32'd0);
      check("sb2_drain", sb2.size(), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

`default_nettype wire
